// File: rtl/udm_bus_pkg.sv
// Shared definitions for the UDM/core data-memory bus: widths, arbiter FSM states,
// master index type and the watchdog read-data default.
package udm_bus_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned N_MASTERS   = 2;

  localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef logic master_idx_t;

endpackage

// File: rtl/udm_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the master that did not win last time gets the grant.
module udm_rr_arb2
  import udm_bus_pkg::*;
(
  input  logic [N_MASTERS-1:0] req,
  input  master_idx_t          last_grant,
  output master_idx_t          grant_c,
  output logic                 valid_c
);

  always_comb begin
    valid_c = |req;
    grant_c = master_idx_t'(1'b0);
    if (&req) begin
      grant_c = ~last_grant;
    end else if (req[1]) begin
      grant_c = master_idx_t'(1'b1);
    end
  end

endmodule

// File: rtl/udm_mem_arbiter.sv
// Core/UDM arbiter for one data-memory bank: round-robin grant, one outstanding
// transaction, and a read-response watchdog that returns TIMEOUT_DATA on a hung slave.
module udm_mem_arbiter
  import udm_bus_pkg::*;
#(
  parameter int unsigned        ADDR_W       = ADDR_W_DEF,
  parameter int unsigned        DATA_W       = DATA_W_DEF,
  parameter int unsigned        TIMEOUT      = TIMEOUT_DEF,
  parameter logic [DATA_W-1:0]  TIMEOUT_DATA = DATA_W'(TIMEOUT_DATA_DEF)
) (
  input  logic                clk_i,
  input  logic                arst_n_i,

  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic                m0_ack_o,
  output logic                m0_resp_o,
  output logic [DATA_W-1:0]   m0_rdata_o,

  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic                m1_ack_o,
  output logic                m1_resp_o,
  output logic [DATA_W-1:0]   m1_rdata_o,

  output logic                s_req_o,
  output logic                s_we_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W/8-1:0] s_be_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  input  logic                s_ack_i,
  input  logic                s_resp_i,
  input  logic [DATA_W-1:0]   s_rdata_i,

  output logic                timeout_o
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
  localparam logic             WD_EN     = (TIMEOUT != 0);

  arb_state_e       state_q, state_d;
  master_idx_t      owner_q, owner_d;
  master_idx_t      last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  master_idx_t      grant_c;
  logic             grant_valid_c;

  logic              own_req_c;
  logic              own_we_c;
  logic [ADDR_W-1:0] own_addr_c;
  logic [BE_W-1:0]   own_be_c;
  logic [DATA_W-1:0] own_wdata_c;
  logic              expire_c;
  logic              resp_fire_c;
  logic [DATA_W-1:0] resp_data_c;

  udm_rr_arb2 u_rr_arb2 (
    .req        ({m1_req_i, m0_req_i}),
    .last_grant (last_grant_q),
    .grant_c    (grant_c),
    .valid_c    (grant_valid_c)
  );

  // Request fields of the current owner
  assign own_req_c   = owner_q ? m1_req_i   : m0_req_i;
  assign own_we_c    = owner_q ? m1_we_i    : m0_we_i;
  assign own_addr_c  = owner_q ? m1_addr_i  : m0_addr_i;
  assign own_be_c    = owner_q ? m1_be_i    : m0_be_i;
  assign own_wdata_c = owner_q ? m1_wdata_i : m0_wdata_i;

  // A real response in the expiry cycle wins over the watchdog
  assign expire_c    = WD_EN && (state_q == RESP) && (cnt_q == CNT_LIMIT) && !s_resp_i;
  assign resp_fire_c = (state_q == RESP) && (s_resp_i || expire_c);
  assign resp_data_c = s_resp_i ? s_rdata_i : TIMEOUT_DATA;

  assign timeout_o = timeout_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q      <= IDLE;
      owner_q      <= master_idx_t'(1'b0);
      last_grant_q <= master_idx_t'(1'b1);
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next-state, ownership, fairness and watchdog updates
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
    case (state_q)
      IDLE: begin
        if (grant_valid_c) begin
          owner_d = grant_c;
          state_d = REQ;
        end
      end
      REQ: begin
        if (!own_req_c) begin
          state_d = IDLE;
        end else if (s_ack_i) begin
          if (own_we_c) begin
            state_d      = IDLE;
            last_grant_d = owner_q;
          end else begin
            state_d = RESP;
            cnt_d   = '0;
          end
        end
      end
      RESP: begin
        if (s_resp_i || expire_c) begin
          state_d      = IDLE;
          last_grant_d = owner_q;
          if (expire_c) begin
            timeout_d = 1'b1;
          end
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Slave-side mux and owner-only ack/resp routing
  always_comb begin
    s_req_o    = 1'b0;
    s_we_o     = 1'b0;
    s_addr_o   = '0;
    s_be_o     = '0;
    s_wdata_o  = '0;
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m0_resp_o  = 1'b0;
    m1_resp_o  = 1'b0;
    m0_rdata_o = '0;
    m1_rdata_o = '0;
    case (state_q)
      REQ: begin
        s_req_o   = own_req_c;
        s_we_o    = own_we_c;
        s_addr_o  = own_addr_c;
        s_be_o    = own_be_c;
        s_wdata_o = own_wdata_c;
        if (owner_q) begin
          m1_ack_o = s_ack_i && own_req_c;
        end else begin
          m0_ack_o = s_ack_i && own_req_c;
        end
      end
      RESP: begin
        if (resp_fire_c) begin
          if (owner_q) begin
            m1_resp_o  = 1'b1;
            m1_rdata_o = resp_data_c;
          end else begin
            m0_resp_o  = 1'b1;
            m0_rdata_o = resp_data_c;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_udm_mem_arbiter.sv
// Bench for udm_mem_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed latencies, grant orders and data.
module tb_udm_mem_arbiter;
  import udm_bus_pkg::*;

  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req[2];
  logic        we[2];
  logic [31:0] addr[2];
  logic [3:0]  be[2];
  logic [31:0] wdata[2];
  logic        ack[2];
  logic        resp[2];
  logic [31:0] rdata[2];

  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic [3:0]  s_be_o;
  logic        s_ack_i, s_resp_i;
  logic [31:0] s_rdata_i;
  logic        timeout_o;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  udm_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .arst_n_i(rst_n),
    .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]), .m0_be_i(be[0]),
    .m0_wdata_i(wdata[0]), .m0_ack_o(ack[0]), .m0_resp_o(resp[0]), .m0_rdata_o(rdata[0]),
    .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]), .m1_be_i(be[1]),
    .m1_wdata_i(wdata[1]), .m1_ack_o(ack[1]), .m1_resp_o(resp[1]), .m1_rdata_o(rdata[1]),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_be_o(s_be_o),
    .s_wdata_o(s_wdata_o), .s_ack_i(s_ack_i), .s_resp_i(s_resp_i), .s_rdata_i(s_rdata_i),
    .timeout_o(timeout_o)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: ack after ack_delay waiting cycles, read data resp_delay cycles after ack (0 = never)
  int ack_delay = 0;
  int resp_delay = 1;
  int req_cycles = 0;
  int resp_timer = 0;
  bit force_resp = 1'b0;
  logic [31:0] rd_val = 32'h0;

  assign s_ack_i   = s_req_o && (req_cycles >= ack_delay);
  assign s_resp_i  = (resp_timer == 1) || force_resp;
  assign s_rdata_i = rd_val;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_cycles <= 0;
      resp_timer <= 0;
    end else begin
      req_cycles <= (s_req_o && !s_ack_i) ? req_cycles + 1 : 0;
      if (s_ack_i && !s_we_o) resp_timer <= resp_delay;
      else if (resp_timer > 0) resp_timer <= resp_timer - 1;
    end
  end

  // Reference model: one pending transaction, its owner, and cycles spent waiting for read data
  bit m_busy = 1'b0, m_acked = 1'b0, m_to = 1'b0;
  int m_who = 0, m_last = 1, m_wait = 0;

  always @(negedge clk) begin
    logic        e_sreq, e_we, e_sack, fire_real, fire_to;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    logic        e_ack[2], e_resp[2];
    logic [31:0] e_rdata[2];
    if (!rst_n) begin
      m_busy = 1'b0; m_acked = 1'b0; m_to = 1'b0; m_last = 1; m_wait = 0;
    end
    e_sreq = 1'b0; e_we = 1'b0; e_sack = 1'b0; e_addr = '0; e_wd = '0; e_be = '0;
    fire_real = 1'b0; fire_to = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e_ack[i] = 1'b0; e_resp[i] = 1'b0; e_rdata[i] = '0;
    end
    if (rst_n && m_busy && !m_acked) begin
      e_sreq = req[m_who];
      e_we   = we[m_who];
      e_addr = addr[m_who];
      e_be   = be[m_who];
      e_wd   = wdata[m_who];
      e_sack = e_sreq && (req_cycles >= ack_delay);
      e_ack[m_who] = e_sack;
    end else if (rst_n && m_busy) begin
      fire_real = s_resp_i;
      fire_to   = (m_wait == int'(TO)) && !s_resp_i;
      if (fire_real || fire_to) begin
        e_resp[m_who]  = 1'b1;
        e_rdata[m_who] = fire_real ? s_rdata_i : 32'hDEADBEEF;
      end
    end
    chk("s_req", s_req_o, e_sreq);
    chk("s_we", s_we_o, e_we);
    chk("s_addr", s_addr_o, e_addr);
    chk("s_be", s_be_o, e_be);
    chk("s_wdata", s_wdata_o, e_wd);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m%0d_ack", i), ack[i], e_ack[i]);
      chk($sformatf("m%0d_resp", i), resp[i], e_resp[i]);
      chk($sformatf("m%0d_rdata", i), rdata[i], e_rdata[i]);
    end
    chk("timeout", timeout_o, m_to);
    if (rst_n) begin
      if (!m_busy) begin
        if (req[0] || req[1]) begin
          m_who   = (req[0] && req[1]) ? 1 - m_last : (req[0] ? 0 : 1);
          m_busy  = 1'b1;
          m_acked = 1'b0;
        end
      end else if (!m_acked) begin
        if (!req[m_who]) m_busy = 1'b0;
        else if (e_sack) begin
          if (we[m_who]) begin
            m_busy = 1'b0;
            m_last = m_who;
          end else begin
            m_acked = 1'b1;
            m_wait  = 0;
          end
        end
      end else if (fire_real || fire_to) begin
        m_busy = 1'b0;
        m_last = m_who;
        if (fire_to) m_to = 1'b1;
      end else begin
        m_wait++;
      end
    end
  end

  int glog[$];
  always @(negedge clk) begin
    if (ack[0]) glog.push_back(0);
    if (ack[1]) glog.push_back(1);
  end

  task automatic xfer(input int m, input bit w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, output int t0, output int ta, output int tr,
                      output logic [31:0] rd);
    int n;
    @(posedge clk); #1;
    req[m] = 1'b1; we[m] = w; addr[m] = a; be[m] = b; wdata[m] = d;
    t0 = cyc; ta = -1; tr = -1; rd = '0;
    n = 0;
    while (ta < 0 && n < 40) begin
      @(negedge clk);
      if (ack[m]) ta = cyc;
      n++;
    end
    @(posedge clk); #1;
    req[m] = 1'b0;
    if (ta < 0) chk($sformatf("m%0d_ack_bound", m), 64'd0, 64'd1);
    else if (!w) begin
      n = 0;
      while (tr < 0 && n < 20) begin
        @(negedge clk);
        if (resp[m]) begin
          tr = cyc;
          rd = rdata[m];
        end
        n++;
      end
      if (tr < 0) chk($sformatf("m%0d_resp_bound", m), 64'd0, 64'd1);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: actual expired required finish");
    $fatal(1, "time limit");
  end

  initial begin
    int t0, ta, tr, nack, n;
    logic [31:0] rd;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; be[i] = '0; wdata[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_timeout", timeout_o, 1'b0);
    chk("rst_s_req", s_req_o, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single core read, immediate ack, 1-cycle data
    rd_val = 32'h12345678;
    xfer(0, 1'b0, 32'h40, 4'hF, 32'h0, t0, ta, tr, rd);
    chk("t1_ack_lat", ta - t0, 1);
    chk("t1_resp_lat", tr - t0, 2);
    chk("t1_rdata", rd, 32'h12345678);

    // Both masters issue 4 reads each: grants alternate starting with the core
    do_reset();
    rd_val = 32'h0000_1111;
    glog.delete();
    fork
      begin
        int a0, a1, a2; logic [31:0] r;
        for (int k = 0; k < 4; k++) xfer(0, 1'b0, 32'h200 + 32'(k), 4'hF, 32'h0, a0, a1, a2, r);
      end
      begin
        int b0, b1, b2; logic [31:0] r;
        for (int k = 0; k < 4; k++) xfer(1, 1'b0, 32'h300 + 32'(k), 4'hF, 32'h0, b0, b1, b2, r);
      end
    join
    chk("t2_grant_count", glog.size(), 8);
    for (int k = 0; k < 8 && k < glog.size(); k++)
      chk($sformatf("t2_grant%0d", k), glog[k], k % 2);

    // UDM write with a 3-cycle ack delay: fields held, single ack
    ack_delay = 3;
    nack = 0;
    fork
      xfer(1, 1'b1, 32'h100, 4'b0011, 32'hA5A5A5A5, t0, ta, tr, rd);
      begin
        repeat (7) begin
          @(negedge clk);
          if (s_req_o) begin
            chk("t3_addr", s_addr_o, 32'h100);
            chk("t3_be", s_be_o, 4'b0011);
            chk("t3_wdata", s_wdata_o, 32'hA5A5A5A5);
            chk("t3_we", s_we_o, 1'b1);
          end
          if (ack[1]) nack++;
        end
      end
    join
    chk("t3_ack_pulses", nack, 1);
    chk("t3_ack_lat", ta - t0, 4);
    @(negedge clk);
    chk("t3_idle_after", s_req_o, 1'b0);
    ack_delay = 0;

    // Real data in the same cycle as watchdog expiry
    resp_delay = 5;
    rd_val = 32'hCAFEF00D;
    xfer(0, 1'b0, 32'h44, 4'hF, 32'h0, t0, ta, tr, rd);
    chk("t5_resp_lat", tr - ta, 5);
    chk("t5_rdata", rd, 32'hCAFEF00D);
    @(negedge clk);
    chk("t5_no_timeout", timeout_o, 1'b0);

    // Slave never answers: watchdog returns the default data, sticky flag
    resp_delay = 0;
    xfer(0, 1'b0, 32'h48, 4'hF, 32'h0, t0, ta, tr, rd);
    chk("t4_resp_lat", tr - ta, 5);
    chk("t4_rdata", rd, 32'hDEADBEEF);
    @(negedge clk);
    chk("t4_timeout_set", timeout_o, 1'b1);
    resp_delay = 1;
    rd_val = 32'h0BADF00D;
    xfer(1, 1'b0, 32'h4C, 4'hF, 32'h0, t0, ta, tr, rd);
    chk("t4_next_lat", tr - t0, 2);
    chk("t4_next_rdata", rd, 32'h0BADF00D);
    chk("t4_timeout_sticky", timeout_o, 1'b1);

    // Reset while waiting for read data, then a late response
    resp_delay = 0;
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h80;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack[0] && n < 20);
    if (!ack[0]) chk("t6_ack_bound", 64'd0, 64'd1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_resp", resp[0], 1'b0);
    chk("t6_rst_timeout", timeout_o, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    resp_delay = 1;
    rd_val = 32'h99;
    force_resp = 1'b1;
    @(negedge clk);
    chk("t6_late_resp0", resp[0], 1'b0);
    chk("t6_late_rdata0", rdata[0], 32'h0);
    @(posedge clk); #1;
    force_resp = 1'b0;
    glog.delete();
    fork
      begin
        int a0, a1, a2; logic [31:0] r;
        xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, a0, a1, a2, r);
      end
      begin
        int b0, b1, b2; logic [31:0] r;
        xfer(1, 1'b0, 32'h14, 4'hF, 32'h0, b0, b1, b2, r);
      end
    join
    chk("t6_grant_count", glog.size(), 2);
    if (glog.size() >= 2) begin
      chk("t6_first_grant", glog[0], 0);
      chk("t6_second_grant", glog[1], 1);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/udm_mem_arbiter.md
# udm_mem_arbiter

Two-master, one-slave arbiter that shares a single data-memory bank in the riscv_udm_memsplit SoC between the RISC-V core data port (master 0) and the UART debug master (master 1). Uses the req/ack/resp memory bus. Round-robin grant, one outstanding transaction at a time, and a response watchdog so a hung slave cannot lock out the debug path. Sits between the core/UDM bus ports and the data RAM.

## Interface

- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables DATA_W/8)
- TIMEOUT, 255, max cycles waiting for s_resp_i after a read ack; 0 disables watchdog
- TIMEOUT_DATA, 32'hDEADBEEF, rdata returned on watchdog expiry
- clk_i  in  1  sole clock, all logic rising-edge
- arst_n_i  in  1  asynchronous active-low reset
- mN_req_i  in  1  master N request (N = 0 core, 1 UDM)
- mN_we_i  in  1  1 = write, 0 = read
- mN_addr_i  in  ADDR_W  address
- mN_be_i  in  DATA_W/8  byte enables
- mN_wdata_i  in  DATA_W  write data
- mN_ack_o  out  1  request accepted
- mN_resp_o  out  1  read data valid, one-cycle pulse
- mN_rdata_o  out  DATA_W  read data, valid with mN_resp_o
- s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o  out  1/1/ADDR_W/DATA_W/8/DATA_W  to memory
- s_ack_i  in  1  memory accepted request
- s_resp_i  in  1  memory read data valid
- s_rdata_i  in  DATA_W  memory read data
- timeout_o  out  1  sticky, set on watchdog expiry, cleared only by reset

## Operation

- Bus rule: master holds req and all fields stable until req & ack in the same cycle; writes complete at ack, reads complete at resp.
- FSM states: IDLE, REQ, RESP.
- IDLE: if any mN_req_i, register owner and go REQ. Both requesting: grant master != last_grant. last_grant resets to 1, so the core wins the first tie.
- REQ: s_req_o = owner's req; s_we/addr/be/wdata muxed from owner; owner's ack_o = s_ack_i. Other master sees ack_o = 0. On s_ack_i: write -> IDLE, last_grant = owner; read -> RESP, clear watchdog counter. If owner drops req before ack (protocol violation): abort, back to IDLE, no last_grant update.
- RESP: s_req_o = 0, no new request accepted. On s_resp_i: owner's resp_o = 1, rdata_o = s_rdata_i (combinational pass-through), last_grant = owner, -> IDLE. Counter increments each cycle; if TIMEOUT != 0 and counter reaches TIMEOUT with no resp: owner gets resp_o = 1, rdata_o = TIMEOUT_DATA, timeout_o set, -> IDLE. s_resp_i simultaneous with expiry: real data wins, no timeout.
- s_resp_i outside RESP is ignored. Non-owner resp_o always 0; rdata_o of non-owner is 0.
- Counter width clog2(TIMEOUT+1), saturates; no wrap.

## Timing

- Reset (async assert, sync-safe release): state IDLE, owner 0, last_grant 1, counter 0, timeout_o 0; all s_* and mN_* outputs 0.
- Arbitration costs one cycle: req seen in cycle t -> s_req_o in t+1. With s_ack_i = 1 immediately: ack at t+1; single-cycle RAM resp at t+2.
- Back-to-back from one master: IDLE cycle between transactions, so max one transaction per 2 cycles (write) / 3 cycles (1-latency read).
- Alternating fairness: with both requesting continuously, grants alternate 0,1,0,1.
- Watchdog expiry: resp_o asserted in the cycle counter == TIMEOUT, i.e. TIMEOUT+1 cycles after read ack.
- Reset mid-transaction: pending transaction dropped, no resp delivered.

## Structure

- Shared package udm_bus_pkg: bus width constants, FSM state enum (IDLE/REQ/RESP), master-index typedef, TIMEOUT_DATA default.
- One sub-module: udm_rr_arb2 (2-way round-robin pick from req vector and last_grant). FSM, muxes and watchdog stay in the top.

## Test plan

- Single core read, RAM acks immediately, resp next cycle with 32'h12345678 -> m0_ack at t+1, m0_resp with 32'h12345678 at t+2, m1 outputs stay 0.
- Both masters request reads in the same cycle after reset -> core granted first, UDM second; grant order alternates over 8 simultaneous requests.
- UDM write addr 32'h100, be 4'b0011, wdata 32'hA5A5A5A5 while RAM delays ack 3 cycles -> s_* fields stable throughout, m1_ack exactly one cycle, FSM back to IDLE.
- Read with TIMEOUT=4, slave never responds -> m0_resp with 32'hDEADBEEF 5 cycles after ack, timeout_o stays 1; next request served normally.
- s_resp_i arrives in the same cycle as expiry -> real data returned, timeout_o stays 0.
- arst_n_i asserted in RESP, then a late s_resp_i after release -> ignored, all outputs 0, next request arbitrated with core priority.
